// File: rtl/cordic_engine.sv
// -----------------------------------------------------------------------------
// cordic_engine
//   Iterative CORDIC unit. One micro-rotation per clock.
//   Rotation mode rotates (x, y) by an integer-degree angle.
//   Vectoring mode returns magnitude, residual and angle of (x, y).
//
// Ports
//   i_clk     : clock, all state updates on its rising edge
//   i_rst_n   : asynchronous active-low reset
//   i_valid   : request valid (sampled only in IDLE)
//   o_ready   : high while idle and able to accept a request
//   i_mode    : 0 = rotation, 1 = vectoring
//   i_x, i_y  : signed input vector, VEC_WIDTH bits
//   i_angle   : signed rotation angle in degrees, ANG_WIDTH bits
//   o_valid   : result valid, held until i_ready
//   i_ready   : consumer accepts the result
//   o_x, o_y  : signed result vector, VEC_WIDTH bits
//   o_angle   : signed result angle in degrees, ANG_WIDTH bits
// -----------------------------------------------------------------------------
module cordic_engine #(
   parameter int VEC_WIDTH         = 7,
   parameter int ANG_WIDTH         = 9,
   parameter int VEC_PROCESS_WIDTH = 16,
   parameter int ANG_PROCESS_WIDTH = 16,
   parameter int ITERATIONS        = 12
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic                        i_valid,
   output logic                        o_ready,
   input  logic                        i_mode,
   input  logic signed [VEC_WIDTH-1:0] i_x,
   input  logic signed [VEC_WIDTH-1:0] i_y,
   input  logic signed [ANG_WIDTH-1:0] i_angle,
   output logic                        o_valid,
   input  logic                        i_ready,
   output logic signed [VEC_WIDTH-1:0] o_x,
   output logic signed [VEC_WIDTH-1:0] o_y,
   output logic signed [ANG_WIDTH-1:0] o_angle
);

   localparam int VPW         = VEC_PROCESS_WIDTH;
   localparam int APW         = ANG_PROCESS_WIDTH;
   localparam int GUARD_SHIFT = VPW - VEC_WIDTH - 1;   // one guard bit above the input MSB
   localparam int ANG_FRAC    = APW - ANG_WIDTH;       // fractional degree bits
   localparam int CNT_W       = 4;                     // covers up to 15 iterations
   localparam int INV_K_FRAC  = 16;
   localparam int PROD_W      = VPW + INV_K_FRAC + 1;
   localparam logic [16:0] INV_K = 17'd39797;          // round(0.607253 * 2^16)
   localparam int VEC_MAX     = (1 << (VEC_WIDTH - 1)) - 1;
   localparam int VEC_MIN     = -(1 << (VEC_WIDTH - 1));
   // The atan source table holds 16 fractional bits; reduce it to ANG_FRAC bits.
   localparam int          ATAN_SH   = (ANG_FRAC >= 16) ? 0 : 16 - ANG_FRAC;
   localparam logic [31:0] ATAN_HALF = (32'd1 << ATAN_SH) >> 1;

   typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

   // atan(2^-i) in degrees, 16 fractional bits
   function automatic logic [31:0] atan_q16(input int idx);
      case (idx)
         0:       return 32'd2949120;
         1:       return 32'd1740967;
         2:       return 32'd919879;
         3:       return 32'd466945;
         4:       return 32'd234379;
         5:       return 32'd117304;
         6:       return 32'd58666;
         7:       return 32'd29335;
         8:       return 32'd14668;
         9:       return 32'd7334;
         10:      return 32'd3667;
         11:      return 32'd1833;
         12:      return 32'd917;
         13:      return 32'd458;
         14:      return 32'd229;
         default: return 32'd0;
      endcase
   endfunction

   // Multiply by 1/K as a sum of shifted copies of the operand, rounded.
   function automatic logic signed [VPW-1:0] prescale(input logic signed [VPW-1:0] v);
      logic signed [PROD_W-1:0] ext;
      logic signed [PROD_W-1:0] acc;
      ext = {{(PROD_W - VPW){v[VPW-1]}}, v};
      acc = '0;
      for (int b = 0; b < 17; b++) begin
         if (INV_K[b]) acc = acc + (ext <<< b);
      end
      acc = acc + (PROD_W'(1) <<< (INV_K_FRAC - 1));
      return acc[INV_K_FRAC +: VPW];
   endfunction

   // Drop the guard/fraction bits with half-LSB rounding and saturate.
   function automatic logic signed [VEC_WIDTH-1:0] scale_vec(input logic signed [VPW-1:0] v);
      int t;
      t = (int'(v) + (1 << (GUARD_SHIFT - 1))) >>> GUARD_SHIFT;
      if (t > VEC_MAX)      t = VEC_MAX;
      else if (t < VEC_MIN) t = VEC_MIN;
      return VEC_WIDTH'(t);
   endfunction

   function automatic logic signed [VEC_WIDTH-1:0] neg_sat(input logic signed [VEC_WIDTH-1:0] v);
      int t;
      t = -int'(v);
      if (t > VEC_MAX) t = VEC_MAX;
      return VEC_WIDTH'(t);
   endfunction

   // Round half up, then wrap into (-180, 180].
   function automatic logic signed [ANG_WIDTH-1:0] round_ang(input logic signed [APW-1:0] z);
      int t;
      t = (int'(z) + (1 << (ANG_FRAC - 1))) >>> ANG_FRAC;
      if (t > 180)        t = t - 360;
      else if (t <= -180) t = t + 360;
      return ANG_WIDTH'(t);
   endfunction

   // ---------------------------------------------------------------- atan table
   logic [APW-1:0] atan_tab [ITERATIONS];

   genvar gi;
   generate
      for (gi = 0; gi < ITERATIONS; gi++) begin : g_atan
         localparam logic [31:0] ATAN_RAW = atan_q16(gi);
         localparam logic [31:0] ATAN_RND = (ATAN_RAW + ATAN_HALF) >> ATAN_SH;
         assign atan_tab[gi] = ATAN_RND[APW-1:0];
      end
   endgenerate

   // ---------------------------------------------------------------- registers
   state_t                       state_reg;
   logic [CNT_W-1:0]             iter_cnt_reg;
   logic signed [VPW-1:0]        x_reg, y_reg;
   logic signed [APW-1:0]        z_reg;
   logic                         mode_reg, flip_reg, zero_reg;
   logic signed [ANG_WIDTH-1:0]  ang_echo_reg;
   logic                         o_ready_reg, o_valid_reg;
   logic signed [VEC_WIDTH-1:0]  o_x_reg, o_y_reg;
   logic signed [ANG_WIDTH-1:0]  o_angle_reg;

   // ---------------------------------------------------------------- capture
   logic signed [VPW-1:0]        x_cap_next, y_cap_next;
   logic signed [APW-1:0]        z_cap_next;
   logic                         flip_cap_next, zero_cap_next;
   logic signed [ANG_WIDTH-1:0]  ang_echo_next;

   always_comb begin
      int                    ang_clamp;
      int                    ang_fold;
      int                    acc_init;
      logic signed [VPW-1:0] x_ext, y_ext, x_fold, y_fold;

      ang_clamp = int'(i_angle);
      if (ang_clamp > 180)       ang_clamp = 180;
      else if (ang_clamp < -180) ang_clamp = -180;

      // Bring the rotation into [-90, 90]; the half-turn is restored by negating the result.
      flip_cap_next = 1'b0;
      ang_fold      = ang_clamp;
      if (ang_clamp > 90) begin
         ang_fold      = ang_clamp - 180;
         flip_cap_next = 1'b1;
      end else if (ang_clamp < -90) begin
         ang_fold      = ang_clamp + 180;
         flip_cap_next = 1'b1;
      end

      x_ext = {{(VPW - VEC_WIDTH){i_x[VEC_WIDTH-1]}}, i_x};
      y_ext = {{(VPW - VEC_WIDTH){i_y[VEC_WIDTH-1]}}, i_y};
      x_ext = x_ext <<< GUARD_SHIFT;
      y_ext = y_ext <<< GUARD_SHIFT;

      x_fold        = x_ext;
      y_fold        = y_ext;
      zero_cap_next = 1'b0;
      if (i_mode) begin
         // Vectoring only converges for x >= 0: reflect through the origin
         // and pre-load the half-turn with the sign of the original y.
         zero_cap_next = (i_x == '0) && (i_y == '0);
         acc_init      = 0;
         if (x_ext < 0) begin
            x_fold   = -x_ext;
            y_fold   = -y_ext;
            acc_init = (i_y >= 0) ? 180 : -180;
         end
      end else begin
         acc_init = ang_fold;
      end

      x_cap_next    = prescale(x_fold);
      y_cap_next    = prescale(y_fold);
      z_cap_next    = APW'(acc_init * (1 << ANG_FRAC));
      ang_echo_next = ANG_WIDTH'(ang_clamp);
   end

   // ---------------------------------------------------------------- micro-rotation
   logic signed [VPW-1:0] x_next, y_next;
   logic signed [APW-1:0] z_next;

   always_comb begin
      logic signed [VPW-1:0] x_sh, y_sh;
      logic signed [APW-1:0] atan_cur;
      x_sh     = x_reg >>> iter_cnt_reg;
      y_sh     = y_reg >>> iter_cnt_reg;
      atan_cur = $signed(atan_tab[iter_cnt_reg]);
      // Both modes share the same two step directions; only the decision differs.
      if (mode_reg ? !y_reg[VPW-1] : z_reg[APW-1]) begin
         x_next = x_reg + y_sh;
         y_next = y_reg - x_sh;
         z_next = z_reg + atan_cur;
      end else begin
         x_next = x_reg - y_sh;
         y_next = y_reg + x_sh;
         z_next = z_reg - atan_cur;
      end
   end

   // ---------------------------------------------------------------- result formatting
   logic signed [VEC_WIDTH-1:0] res_x_next, res_y_next;
   logic signed [ANG_WIDTH-1:0] res_ang_next;

   always_comb begin
      logic signed [VEC_WIDTH-1:0] sx, sy;
      sx           = scale_vec(x_next);
      sy           = scale_vec(y_next);
      res_x_next   = sx;
      res_y_next   = sy;
      res_ang_next = ang_echo_reg;
      if (zero_reg) begin
         res_x_next   = '0;
         res_y_next   = '0;
         res_ang_next = '0;
      end else if (mode_reg) begin
         res_ang_next = round_ang(z_next);
      end else if (flip_reg) begin
         res_x_next = neg_sat(sx);
         res_y_next = neg_sat(sy);
      end
   end

   // ---------------------------------------------------------------- FSM + datapath
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg    <= IDLE;
         iter_cnt_reg <= '0;
         x_reg        <= '0;
         y_reg        <= '0;
         z_reg        <= '0;
         mode_reg     <= 1'b0;
         flip_reg     <= 1'b0;
         zero_reg     <= 1'b0;
         ang_echo_reg <= '0;
         o_ready_reg  <= 1'b1;
         o_valid_reg  <= 1'b0;
         o_x_reg      <= '0;
         o_y_reg      <= '0;
         o_angle_reg  <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (i_valid) begin
                  x_reg        <= x_cap_next;
                  y_reg        <= y_cap_next;
                  z_reg        <= z_cap_next;
                  mode_reg     <= i_mode;
                  flip_reg     <= flip_cap_next & ~i_mode;
                  zero_reg     <= zero_cap_next;
                  ang_echo_reg <= ang_echo_next;
                  iter_cnt_reg <= '0;
                  o_ready_reg  <= 1'b0;
                  state_reg    <= ITER;
               end
            end
            ITER: begin
               x_reg        <= x_next;
               y_reg        <= y_next;
               z_reg        <= z_next;
               iter_cnt_reg <= iter_cnt_reg + 1'b1;
               if (iter_cnt_reg == CNT_W'(ITERATIONS - 1)) begin
                  // The final step's values are formatted straight into the output registers.
                  o_x_reg     <= res_x_next;
                  o_y_reg     <= res_y_next;
                  o_angle_reg <= res_ang_next;
                  o_valid_reg <= 1'b1;
                  state_reg   <= DONE;
               end
            end
            DONE: begin
               if (i_ready) begin
                  o_valid_reg <= 1'b0;
                  o_ready_reg <= 1'b1;
                  state_reg   <= IDLE;
               end
            end
            default: begin
               state_reg   <= IDLE;
               o_valid_reg <= 1'b0;
               o_ready_reg <= 1'b1;
            end
         endcase
      end
   end

   assign o_ready = o_ready_reg;
   assign o_valid = o_valid_reg;
   assign o_x     = o_x_reg;
   assign o_y     = o_y_reg;
   assign o_angle = o_angle_reg;

endmodule

// File: tb/tb_cordic_engine.sv
// -----------------------------------------------------------------------------
// tb_cordic_engine
//   Directed vectors against cordic_engine with default parameters.
//   Inputs change on the falling edge; outputs are sampled on the falling edge.
//   Latency is counted in cycles after the accept cycle (cycle 1 is the first
//   falling edge after the accept edge).
// -----------------------------------------------------------------------------
module tb_cordic_engine;

   logic              i_clk;
   logic              i_rst_n;
   logic              i_valid;
   logic              o_ready;
   logic              i_mode;
   logic signed [6:0] i_x, i_y;
   logic signed [8:0] i_angle;
   logic              o_valid;
   logic              i_ready;
   logic signed [6:0] o_x, o_y;
   logic signed [8:0] o_angle;

   int vectors     = 0;
   int miscompares = 0;

   cordic_engine dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_mode  (i_mode),
      .i_x     (i_x),
      .i_y     (i_y),
      .i_angle (i_angle),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_x     (o_x),
      .o_y     (o_y),
      .o_angle (o_angle)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input int got, input int exp, input int tol = 0);
      vectors++;
      if (got > exp + tol || got < exp - tol) begin
         miscompares++;
         $display("FAIL %s: observed %0d, expected %0d (tol %0d)", tag, got, exp, tol);
      end
   endtask

   // Issue one request at the current falling edge and wait for o_valid.
   // A few junk i_valid pulses are driven while busy; they must be ignored.
   task automatic run_req(input bit mode, input int x, input int y, input int ang,
                          output int ox, output int oy, output int oa, output int lat);
      i_mode  = mode;
      i_x     = 7'(x);
      i_y     = 7'(y);
      i_angle = 9'(ang);
      i_valid = 1'b1;
      @(posedge i_clk);
      @(negedge i_clk);
      i_valid = 1'b0;
      lat = 1;
      while (!o_valid && lat < 60) begin
         if (lat == 2) begin
            i_valid = 1'b1;
            i_mode  = ~mode;
            i_x     = -7'sd50;
            i_y     = 7'sd17;
            i_angle = -9'sd33;
         end
         if (lat == 5) i_valid = 1'b0;
         @(negedge i_clk);
         lat++;
      end
      if (!o_valid) lat = -1;
      ox = int'(o_x);
      oy = int'(o_y);
      oa = int'(o_angle);
      $display("req mode=%0d x=%0d y=%0d ang=%0d -> o_x=%0d o_y=%0d o_angle=%0d latency=%0d",
               mode, x, y, ang, ox, oy, oa, lat);
   endtask

   task automatic release_res();
      i_ready = 1'b1;
      @(negedge i_clk);
      i_ready = 1'b0;
   endtask

   initial begin
      int ox, oy, oa, lat, seen;

      i_rst_n = 1'b0;
      i_valid = 1'b0;
      i_ready = 1'b0;
      i_mode  = 1'b0;
      i_x     = '0;
      i_y     = '0;
      i_angle = '0;

      // ---- reset state
      repeat (2) @(negedge i_clk);
      chk("rst_ready", int'(o_ready), 1);
      chk("rst_valid", int'(o_valid), 0);
      chk("rst_x",     int'(o_x), 0);
      chk("rst_y",     int'(o_y), 0);
      chk("rst_angle", int'(o_angle), 0);
      i_rst_n = 1'b1;
      @(negedge i_clk);

      // ---- rotate (40,0) by 90
      run_req(1'b0, 40, 0, 90, ox, oy, oa, lat);
      chk("rot90_latency", lat, 13);
      chk("rot90_x", ox, 0, 1);
      chk("rot90_y", oy, 40, 1);
      chk("rot90_angle", oa, 90);
      release_res();

      // ---- rotate by +/-180 (flip path)
      run_req(1'b0, 30, 0, 180, ox, oy, oa, lat);
      chk("rot180_x", ox, -30, 1);
      chk("rot180_y", oy, 0, 1);
      chk("rot180_angle", oa, 180);
      release_res();
      run_req(1'b0, 30, 0, -180, ox, oy, oa, lat);
      chk("rotm180_x", ox, -30, 1);
      chk("rotm180_y", oy, 0, 1);
      chk("rotm180_angle", oa, -180);
      release_res();

      // ---- angle beyond 180 is clamped and echoed as 180
      run_req(1'b0, 20, 0, 250, ox, oy, oa, lat);
      chk("clamp_x", ox, -20, 1);
      chk("clamp_y", oy, 0, 1);
      chk("clamp_angle", oa, 180);
      release_res();

      // ---- flip of -64 saturates to +63
      run_req(1'b0, -64, 0, 180, ox, oy, oa, lat);
      chk("negsat_x", ox, 63);
      chk("negsat_y", oy, 0, 1);
      release_res();

      // ---- vectoring
      run_req(1'b1, -30, 30, 0, ox, oy, oa, lat);
      chk("vec_q2_mag", ox, 42, 1);
      chk("vec_q2_angle", oa, 135, 1);
      chk("vec_q2_resid", oy, 0, 1);
      release_res();
      run_req(1'b1, -30, -1, 0, ox, oy, oa, lat);
      chk("vec_q3_angle", oa, -178, 1);
      chk("vec_q3_mag", ox, 30, 1);
      release_res();
      run_req(1'b1, 30, 40, 0, ox, oy, oa, lat);
      chk("vec_q1_mag", ox, 50, 1);
      chk("vec_q1_angle", oa, 53, 1);
      release_res();
      run_req(1'b1, -30, 0, 0, ox, oy, oa, lat);
      chk("vec_neg_axis_angle", oa, 180, 1);
      chk("vec_neg_axis_mag", ox, 30, 1);
      release_res();
      run_req(1'b1, 0, 0, 0, ox, oy, oa, lat);
      chk("vec_zero_x", ox, 0);
      chk("vec_zero_y", oy, 0);
      chk("vec_zero_angle", oa, 0);
      release_res();

      // ---- saturation on rotate (63,63) by 45, then backpressure in DONE
      run_req(1'b0, 63, 63, 45, ox, oy, oa, lat);
      chk("sat_y", oy, 63);
      chk("sat_x", ox, 0, 1);
      for (int k = 0; k < 5; k++) begin
         @(negedge i_clk);
         chk("bp_valid", int'(o_valid), 1);
         chk("bp_ready", int'(o_ready), 0);
         chk("bp_y", int'(o_y), 63);
         chk("bp_angle", int'(o_angle), 45);
         chk("bp_x", int'(o_x), 0, 1);
      end
      release_res();
      chk("bp_ready_after", int'(o_ready), 1);
      chk("bp_valid_after", int'(o_valid), 0);
      run_req(1'b0, 40, 0, 90, ox, oy, oa, lat);
      chk("bp_next_latency", lat, 13);
      chk("bp_next_y", oy, 40, 1);
      release_res();

      // ---- reset pulse while the counter is at 5
      i_mode  = 1'b0;
      i_x     = 7'sd25;
      i_y     = 7'sd0;
      i_angle = 9'sd30;
      i_valid = 1'b1;
      @(posedge i_clk);
      @(negedge i_clk);          // cycle 1, counter 0
      i_valid = 1'b0;
      repeat (5) @(negedge i_clk); // cycle 6, counter 5
      i_rst_n = 1'b0;
      #1;
      chk("abort_x", int'(o_x), 0);
      chk("abort_y", int'(o_y), 0);
      chk("abort_angle", int'(o_angle), 0);
      chk("abort_ready", int'(o_ready), 1);
      chk("abort_valid", int'(o_valid), 0);
      @(negedge i_clk);
      chk("abort_ready_held", int'(o_ready), 1);
      i_rst_n = 1'b1;
      seen = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge i_clk);
         if (o_valid) seen++;
      end
      $display("abort: o_valid cycles after reset release=%0d", seen);
      chk("abort_no_valid", seen, 0);
      chk("abort_idle_ready", int'(o_ready), 1);
      run_req(1'b1, 30, 40, 0, ox, oy, oa, lat);
      chk("post_abort_latency", lat, 13);
      chk("post_abort_mag", ox, 50, 1);
      chk("post_abort_angle", oa, 53, 1);
      release_res();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
